// File: rtl/ram_loader.sv
// ram_loader: byte-stream loader into SB_RAM256x16-style 16-bit banks with an 8-bit read-back port.
// Define RAM_LOADER_CHECKSUM_EN to build the running mod-256 checksum on sum_o.
module ram_loader #(
    parameter int VECTOR_LENGTH = 512,
    parameter int ADDR_WIDTH = $clog2(VECTOR_LENGTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic [7:0]            data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic [7:0]            sum_o,
    input  logic                  rclke_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [7:0]            rdata_o
);
    localparam int NB = (VECTOR_LENGTH + 511) / 512;
    localparam int BW = NB > 1 ? $clog2(NB) : 1;
    localparam logic [ADDR_WIDTH:0] VMAX = (ADDR_WIDTH + 1)'(VECTOR_LENGTH);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, FIN = 2'd2;

    logic [1:0] state;
    logic [ADDR_WIDTH:0] len, count, count_nxt;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [BW-1:0] wbank, rbank, rsel;
    logic [7:0] wword, rword;
    logic accept, take_start, rhi;
    logic [NB-1:0] we, re;
    logic [15:0] rd [NB];
    logic [15:0] q;

    assign ready_o = state == LOAD;
    assign busy_o = state == LOAD;
    assign done_o = state == FIN;
    assign count_o = count;
    assign accept = valid_i && ready_o;
    assign take_start = start_i && state == IDLE;
    assign count_nxt = count + (ADDR_WIDTH + 1)'(1);
    assign waddr = count[ADDR_WIDTH-1:0];
    assign wbank = BW'(waddr >> 9);
    assign wword = 8'(waddr >> 1);
    assign rbank = BW'(raddr_i >> 9);
    assign rword = 8'(raddr_i >> 1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            count <= '0;
        end else if (take_start) begin
            count <= '0;
            len <= len_i > VMAX ? VMAX : len_i;
            state <= len_i == '0 ? FIN : LOAD;
        end else if (accept) begin
            count <= count_nxt;
            state <= count_nxt == len ? FIN : LOAD;
        end else if (state == FIN) begin
            state <= IDLE;
        end
    end

`ifdef RAM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    always_ff @(posedge clk_i) begin
        if (rst_i || take_start)
            sum <= '0;
        else if (accept)
            sum <= sum + data_i;
    end
    assign sum_o = sum;
`else
    assign sum_o = 8'h00;
`endif

    // Each bank sees its own WE/RE; writes touch only the addressed byte lane.
    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [15:0] mem [256];
        logic [15:0] dout;
        assign we[b] = accept && wbank == BW'(b);
        assign re[b] = rclke_i && rbank == BW'(b);
        always_ff @(posedge clk_i) begin
            if (we[b]) begin
                if (waddr[0])
                    mem[wword][15:8] <= data_i;
                else
                    mem[wword][7:0] <= data_i;
            end
            if (re[b])
                dout <= mem[rword];
        end
        assign rd[b] = dout;
    end

    always_ff @(posedge clk_i) begin
        if (rclke_i) begin
            rsel <= rbank;
            rhi <= raddr_i[0];
        end
    end

    always_comb begin
        q = '0;
        for (int i = 0; i < NB; i++)
            if (rsel == BW'(i))
                q = rd[i];
    end

    assign rdata_o = rhi ? q[15:8] : q[7:0];
endmodule
